// File: rtl/subservient_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | subservient_pkg : shared loader state encodings and SRAM data width        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package subservient_pkg;

  localparam int SRAM_DW = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } ld_state_e;

endpackage
`default_nettype wire

// File: rtl/subservient_sram_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | subservient_sram_array : memsize x 8 1W1R array, registered read-first port |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module subservient_sram_array
  import subservient_pkg::*;
#(
  parameter int memsize = 1024,
  parameter int AW      = $clog2(memsize)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_wen,
  input  logic [AW-1:0]      i_waddr,
  input  logic [SRAM_DW-1:0] i_wdata,
  input  logic [AW-1:0]      i_raddr,
  output logic [SRAM_DW-1:0] o_rdata
);

  logic [SRAM_DW-1:0] r_mem [memsize];

  // Contents are deliberately not reset so a reset mid-load keeps written bytes.
  always_ff @(posedge i_clk) begin
    if (i_wen) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_rdata <= '0;
    else       o_rdata <= r_mem[i_raddr];
  end

endmodule
`default_nettype wire

// File: rtl/subservient_sram_resp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | subservient_sram_resp : SRAM responder with firmware byte-stream loader     |
// | Optional checksum output: define SUBSERVIENT_SRAM_CSUM_EN.  Rev 1.0         |
// +----------------------------------------------------------------------------+
module subservient_sram_resp
  import subservient_pkg::*;
#(
  parameter int memsize   = 1024,
  parameter int BOOT_LOAD = 0,
  localparam int AW       = $clog2(memsize)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [AW-1:0]      i_sram_waddr,
  input  logic [SRAM_DW-1:0] i_sram_wdata,
  input  logic               i_sram_wen,
  input  logic [AW-1:0]      i_sram_raddr,
  output logic [SRAM_DW-1:0] o_sram_rdata,
  input  logic               i_ld_start,
  input  logic               i_ld_valid,
  input  logic [SRAM_DW-1:0] i_ld_data,
  input  logic               i_ld_last,
  output logic               o_ld_ready,
  output logic               o_ld_busy,
  output logic               o_core_rst
`ifdef SUBSERVIENT_SRAM_CSUM_EN
  ,
  output logic [SRAM_DW-1:0] o_ld_csum
`endif
);

  localparam logic [AW-1:0] c_last_addr = AW'(memsize - 1);
  localparam ld_state_e     c_rst_state = (BOOT_LOAD != 0) ? LOAD : IDLE;

  ld_state_e          r_state;
  ld_state_e          w_state_nxt;
  logic [AW-1:0]      r_ld_addr;
  logic               w_accept;
  logic               w_ld_wen;
  logic               w_core_wen;
  logic               w_wen;
  logic [AW-1:0]      w_waddr;
  logic [SRAM_DW-1:0] w_wdata;

  // Restart wins over a byte offered in the same cycle.
  assign w_accept   = (r_state == LOAD) && i_ld_valid;
  assign w_ld_wen   = w_accept && !i_ld_start;
  assign w_core_wen = (r_state == IDLE) && i_sram_wen;
  assign w_wen      = w_ld_wen || w_core_wen;
  assign w_waddr    = w_ld_wen ? r_ld_addr : i_sram_waddr;
  assign w_wdata    = w_ld_wen ? i_ld_data : i_sram_wdata;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_ld_start) w_state_nxt = LOAD;
      LOAD:    if (i_ld_start) w_state_nxt = LOAD;
               else if (w_accept && (i_ld_last || r_ld_addr == c_last_addr))
                 w_state_nxt = FLUSH;
      FLUSH:   w_state_nxt = i_ld_start ? LOAD : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they track r_state exactly.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= c_rst_state;
      r_ld_addr  <= '0;
      o_ld_ready <= (BOOT_LOAD != 0);
      o_ld_busy  <= (BOOT_LOAD != 0);
      o_core_rst <= (BOOT_LOAD != 0);
    end else begin
      r_state    <= w_state_nxt;
      o_ld_ready <= (w_state_nxt == LOAD);
      o_ld_busy  <= (w_state_nxt != IDLE);
      o_core_rst <= (w_state_nxt != IDLE);
      if (i_ld_start)    r_ld_addr <= '0;
      else if (w_ld_wen) r_ld_addr <= r_ld_addr + 1'b1;
    end
  end

`ifdef SUBSERVIENT_SRAM_CSUM_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)         o_ld_csum <= '0;
    else if (i_ld_start) o_ld_csum <= '0;
    else if (w_ld_wen) o_ld_csum <= o_ld_csum + i_ld_data;
  end
`endif

  subservient_sram_array #(
    .memsize (memsize),
    .AW      (AW)
  ) u_array (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_wen   (w_wen),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (i_sram_raddr),
    .o_rdata (o_sram_rdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_subservient_sram_resp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_subservient_sram_resp : directed vectors for the SRAM responder/loader   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_subservient_sram_resp;

  localparam int MEMSIZE = 1024;
  localparam int AW      = 10;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic [AW-1:0] i_sram_waddr = '0;
  logic [7:0]    i_sram_wdata = '0;
  logic          i_sram_wen   = 1'b0;
  logic [AW-1:0] i_sram_raddr = '0;
  logic [7:0]    o_sram_rdata;
  logic          i_ld_start = 1'b0;
  logic          i_ld_valid = 1'b0;
  logic [7:0]    i_ld_data  = '0;
  logic          i_ld_last  = 1'b0;
  logic          o_ld_ready;
  logic          o_ld_busy;
  logic          o_core_rst;
`ifdef SUBSERVIENT_SRAM_CSUM_EN
  logic [7:0]    o_ld_csum;
`endif

  subservient_sram_resp #(.memsize(MEMSIZE), .BOOT_LOAD(0)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_sram_waddr (i_sram_waddr),
    .i_sram_wdata (i_sram_wdata),
    .i_sram_wen   (i_sram_wen),
    .i_sram_raddr (i_sram_raddr),
    .o_sram_rdata (o_sram_rdata),
    .i_ld_start   (i_ld_start),
    .i_ld_valid   (i_ld_valid),
    .i_ld_data    (i_ld_data),
    .i_ld_last    (i_ld_last),
    .o_ld_ready   (o_ld_ready),
    .o_ld_busy    (o_ld_busy),
    .o_core_rst   (o_core_rst)
`ifdef SUBSERVIENT_SRAM_CSUM_EN
    ,
    .o_ld_csum    (o_ld_csum)
`endif
  );

  always #5 i_clk = ~i_clk;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic          wen;
    logic [AW-1:0] waddr;
    logic [7:0]    wdata;
    logic [AW-1:0] raddr;
    logic          chk;
    logic [7:0]    exp;
  } vec_t;

  vec_t vt [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [7:0] e, input string nm);
    i_sram_wen   = 1'b0;
    i_sram_raddr = a;
    tick();
    check(nm, {24'd0, o_sram_rdata}, {24'd0, e});
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    i_ld_valid = 1'b1;
    i_ld_data  = d;
    i_ld_last  = last;
    tick();
    i_ld_valid = 1'b0;
    i_ld_last  = 1'b0;
  endtask

  logic [7:0] csum_model;
  logic [7:0] b;

  initial begin
    // core-port vectors, all in IDLE; exp is rdata one cycle after raddr
    vt[0]  = '{1'b1, 10'h020, 8'h00, 10'h000, 1'b0, 8'h00};
    vt[1]  = '{1'b1, 10'h010, 8'hA5, 10'h020, 1'b1, 8'h00};
    vt[2]  = '{1'b0, 10'h000, 8'h00, 10'h010, 1'b1, 8'hA5};
    vt[3]  = '{1'b1, 10'h020, 8'h3C, 10'h020, 1'b1, 8'h00};
    vt[4]  = '{1'b0, 10'h000, 8'h00, 10'h020, 1'b1, 8'h3C};
    vt[5]  = '{1'b1, 10'h030, 8'hFF, 10'h010, 1'b1, 8'hA5};
    vt[6]  = '{1'b1, 10'h031, 8'h01, 10'h030, 1'b1, 8'hFF};
    vt[7]  = '{1'b1, 10'h030, 8'h5A, 10'h031, 1'b1, 8'h01};
    vt[8]  = '{1'b0, 10'h000, 8'h00, 10'h030, 1'b1, 8'h5A};
    vt[9]  = '{1'b1, 10'h3FF, 8'hC3, 10'h030, 1'b1, 8'h5A};
    vt[10] = '{1'b0, 10'h000, 8'h00, 10'h3FF, 1'b1, 8'hC3};
    vt[11] = '{1'b1, 10'h000, 8'h7E, 10'h3FF, 1'b1, 8'hC3};
    vt[12] = '{1'b0, 10'h000, 8'h00, 10'h000, 1'b1, 8'h7E};

    #1;
    check("rst_rdata", {24'd0, o_sram_rdata}, 32'h0);
    check("rst_ready", {31'd0, o_ld_ready}, 32'h0);
    check("rst_busy", {31'd0, o_ld_busy}, 32'h0);
    check("rst_core_rst", {31'd0, o_core_rst}, 32'h0);
`ifdef SUBSERVIENT_SRAM_CSUM_EN
    check("rst_csum", {24'd0, o_ld_csum}, 32'h0);
`endif
    tick();
    tick();
    i_rst = 1'b0;
    tick();

    for (int i = 0; i < 13; i++) begin
      i_sram_wen   = vt[i].wen;
      i_sram_waddr = vt[i].waddr;
      i_sram_wdata = vt[i].wdata;
      i_sram_raddr = vt[i].raddr;
      tick();
      if (vt[i].chk) check($sformatf("vec%0d_rdata", i), {24'd0, o_sram_rdata}, {24'd0, vt[i].exp});
    end
    i_sram_wen = 1'b0;

    // short image: 11,22,33 with last on 33
    i_ld_start = 1'b1;
    tick();
    i_ld_start = 1'b0;
    check("ld3_busy", {31'd0, o_ld_busy}, 32'h1);
    check("ld3_ready", {31'd0, o_ld_ready}, 32'h1);
    check("ld3_core_rst", {31'd0, o_core_rst}, 32'h1);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b1);
    check("ld3_flush_ready", {31'd0, o_ld_ready}, 32'h0);
    check("ld3_flush_core_rst", {31'd0, o_core_rst}, 32'h1);
    tick();
    check("ld3_idle_core_rst", {31'd0, o_core_rst}, 32'h0);
    check("ld3_idle_busy", {31'd0, o_ld_busy}, 32'h0);
`ifdef SUBSERVIENT_SRAM_CSUM_EN
    check("ld3_csum", {24'd0, o_ld_csum}, 32'h66);
`endif
    rd(10'h000, 8'h11, "ld3_mem0");
    rd(10'h001, 8'h22, "ld3_mem1");
    rd(10'h002, 8'h33, "ld3_mem2");

    // full image without last; core write at 0x005 during load must be dropped
    i_ld_start = 1'b1;
    tick();
    i_ld_start = 1'b0;
    csum_model = 8'h00;
    for (int i = 0; i < MEMSIZE; i++) begin
      b = 8'(i) ^ 8'h5A;
      csum_model += b;
      i_sram_wen   = (i == 3);
      i_sram_waddr = 10'h005;
      i_sram_wdata = 8'hEE;
      send(b, 1'b0);
      if (i == MEMSIZE - 2) check("full_pre_end_ready", {31'd0, o_ld_ready}, 32'h1);
    end
    i_sram_wen = 1'b0;
    check("full_flush_ready", {31'd0, o_ld_ready}, 32'h0);
    check("full_flush_core_rst", {31'd0, o_core_rst}, 32'h1);
    tick();
    check("full_idle_core_rst", {31'd0, o_core_rst}, 32'h0);
`ifdef SUBSERVIENT_SRAM_CSUM_EN
    check("full_csum", {24'd0, o_ld_csum}, {24'd0, csum_model});
`endif
    rd(10'h005, 8'h5F, "full_mem5_core_drop");
    rd(10'h3FF, 8'hA5, "full_mem3ff");
    rd(10'h000, 8'h5A, "full_mem0");

    // reset mid-load after four bytes
    i_sram_raddr = 10'h3FF;
    i_ld_start = 1'b1;
    tick();
    i_ld_start = 1'b0;
    send(8'hA0, 1'b0);
    send(8'hA1, 1'b0);
    send(8'hA2, 1'b0);
    send(8'hA3, 1'b0);
    i_ld_valid = 1'b1;
    i_ld_data  = 8'hFF;
    check("mrst_pre_rdata", {24'd0, o_sram_rdata}, 32'hA5);
    #2 i_rst = 1'b1;
    #1;
    check("mrst_rdata", {24'd0, o_sram_rdata}, 32'h0);
    check("mrst_ready", {31'd0, o_ld_ready}, 32'h0);
    check("mrst_busy", {31'd0, o_ld_busy}, 32'h0);
    check("mrst_core_rst", {31'd0, o_core_rst}, 32'h0);
    i_ld_valid = 1'b0;
    tick();
    i_rst = 1'b0;
    tick();
    rd(10'h000, 8'hA0, "mrst_mem0");
    rd(10'h001, 8'hA1, "mrst_mem1");
    rd(10'h002, 8'hA2, "mrst_mem2");
    rd(10'h003, 8'hA3, "mrst_mem3");
    rd(10'h004, 8'h5E, "mrst_mem4");

    // restart during load with a valid byte: byte discarded, next byte at 0
    i_ld_start = 1'b1;
    tick();
    i_ld_start = 1'b0;
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    i_ld_start = 1'b1;
    send(8'h77, 1'b0);
    i_ld_start = 1'b0;
    check("rest_ready", {31'd0, o_ld_ready}, 32'h1);
    send(8'h88, 1'b1);
    tick();
    check("rest_idle_busy", {31'd0, o_ld_busy}, 32'h0);
`ifdef SUBSERVIENT_SRAM_CSUM_EN
    check("rest_csum", {24'd0, o_ld_csum}, 32'h88);
`endif
    rd(10'h000, 8'h88, "rest_mem0");
    rd(10'h001, 8'h02, "rest_mem1");
    rd(10'h002, 8'hA2, "rest_mem2");

    // loader bytes in IDLE are ignored; start+valid in IDLE drops that byte
    check("idle_ready", {31'd0, o_ld_ready}, 32'h0);
    send(8'h99, 1'b0);
    rd(10'h000, 8'h88, "idle_byte_ignored");
    i_ld_start = 1'b1;
    send(8'h55, 1'b0);
    i_ld_start = 1'b0;
    send(8'h66, 1'b1);
    tick();
    rd(10'h000, 8'h66, "idle_start_mem0");
    rd(10'h001, 8'h02, "idle_start_mem1");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
